// File: rtl/score_controller.sv
// Two-player BCD score sequencer: edge-detects point/undo requests, arbitrates round-robin, detects winner.
// Point: pending E0, grant E1, digits E2, winner/IDLE E3; requests arriving while busy stay pending.
module score_controller #(
  parameter int WIN_SCORE = 11
) (
  input  logic       dyn_clk,
  input  logic       reset,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       undo,
  input  logic       new_game,
  output logic [3:0] p1_units,
  output logic [3:0] p1_tens,
  output logic [3:0] p2_units,
  output logic [3:0] p2_tens,
  output logic [1:0] winner,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_CHECK, S_WON} state_t;
  typedef enum logic [1:0] {G_NONE, G_P1, G_P2, G_UNDO} gnt_t;

  state_t      r_state, w_next_state;
  gnt_t        r_gnt, w_gnt;
  logic [2:0]  r_hist;
  logic        r_pend_p1, r_pend_p2, r_pend_undo;
  logic        r_rr_p2;
  logic        r_last_p2;
  logic        r_hist_vld;
  logic [7:0]  r_p1_bcd, r_p2_bcd;
  logic [1:0]  r_winner;

  logic        w_edge_p1, w_edge_p2, w_edge_undo;
  logic        w_take_p1, w_take_p2, w_take_undo, w_rr_flip;
  logic [7:0]  w_upd_bcd;
  logic [6:0]  w_score;
  logic        w_win;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)         return v;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)         return v;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign w_edge_p1   = point_p1 & ~r_hist[0];
  assign w_edge_p2   = point_p2 & ~r_hist[1];
  assign w_edge_undo = undo     & ~r_hist[2];

  assign w_upd_bcd = (r_gnt == G_P2) ? r_p2_bcd : r_p1_bcd;
  assign w_score   = {3'b000, w_upd_bcd[7:4]} * 7'd10 + {3'b000, w_upd_bcd[3:0]};
  assign w_win     = (w_score == 7'(WIN_SCORE));

  assign p1_units = r_p1_bcd[3:0];
  assign p1_tens  = r_p1_bcd[7:4];
  assign p2_units = r_p2_bcd[3:0];
  assign p2_tens  = r_p2_bcd[7:4];
  assign winner   = r_winner;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge dyn_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gnt   <= G_NONE;
    end else begin
      r_state <= w_next_state;
      r_gnt   <= w_gnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_gnt        = r_gnt;
    w_take_p1    = 1'b0;
    w_take_p2    = 1'b0;
    w_take_undo  = 1'b0;
    w_rr_flip    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt = G_NONE;
        if (r_pend_p1 && r_pend_p2) begin
          w_rr_flip = 1'b1;
          w_take_p1 = ~r_rr_p2;
          w_take_p2 = r_rr_p2;
          w_gnt     = r_rr_p2 ? G_P2 : G_P1;
          w_next_state = S_UPDATE;
        end else if (r_pend_p1) begin
          w_take_p1    = 1'b1;
          w_gnt        = G_P1;
          w_next_state = S_UPDATE;
        end else if (r_pend_p2) begin
          w_take_p2    = 1'b1;
          w_gnt        = G_P2;
          w_next_state = S_UPDATE;
        end else if (r_pend_undo) begin
          // An undo with no history is consumed without effect
          w_take_undo = 1'b1;
          if (r_hist_vld) begin
            w_gnt        = G_UNDO;
            w_next_state = S_UPDATE;
          end
        end
      end
      S_UPDATE: w_next_state = (r_gnt == G_UNDO) ? S_IDLE : S_CHECK;
      S_CHECK:  w_next_state = w_win ? S_WON : S_IDLE;
      S_WON:    w_next_state = S_WON;
      default:  w_next_state = S_IDLE;
    endcase
    if (new_game) begin
      w_next_state = S_IDLE;
      w_gnt        = G_NONE;
      w_take_p1    = 1'b0;
      w_take_p2    = 1'b0;
      w_take_undo  = 1'b0;
      w_rr_flip    = 1'b0;
    end
  end

  always_ff @(posedge dyn_clk or negedge reset) begin
    if (!reset) begin
      r_hist      <= 3'b000;
      r_pend_p1   <= 1'b0;
      r_pend_p2   <= 1'b0;
      r_pend_undo <= 1'b0;
      r_rr_p2     <= 1'b0;
      r_last_p2   <= 1'b0;
      r_hist_vld  <= 1'b0;
      r_p1_bcd    <= 8'h00;
      r_p2_bcd    <= 8'h00;
      r_winner    <= 2'b00;
    end else begin
      r_hist <= {undo, point_p2, point_p1};
      if (new_game) begin
        r_pend_p1   <= 1'b0;
        r_pend_p2   <= 1'b0;
        r_pend_undo <= 1'b0;
        r_hist_vld  <= 1'b0;
        r_p1_bcd    <= 8'h00;
        r_p2_bcd    <= 8'h00;
        r_winner    <= 2'b00;
      end else if (r_state == S_WON) begin
        r_pend_p1   <= 1'b0;
        r_pend_p2   <= 1'b0;
        r_pend_undo <= 1'b0;
      end else begin
        r_pend_p1   <= (r_pend_p1   & ~w_take_p1)   | w_edge_p1;
        r_pend_p2   <= (r_pend_p2   & ~w_take_p2)   | w_edge_p2;
        r_pend_undo <= (r_pend_undo & ~w_take_undo) | w_edge_undo;
        if (w_rr_flip) r_rr_p2 <= ~r_rr_p2;
        if (r_state == S_UPDATE) begin
          case (r_gnt)
            G_P1: begin
              r_p1_bcd   <= bcd_inc(r_p1_bcd);
              r_last_p2  <= 1'b0;
              r_hist_vld <= 1'b1;
            end
            G_P2: begin
              r_p2_bcd   <= bcd_inc(r_p2_bcd);
              r_last_p2  <= 1'b1;
              r_hist_vld <= 1'b1;
            end
            G_UNDO: begin
              if (r_last_p2) r_p2_bcd <= bcd_dec(r_p2_bcd);
              else           r_p1_bcd <= bcd_dec(r_p1_bcd);
              r_hist_vld <= 1'b0;
            end
            default: ;
          endcase
        end
        if (r_state == S_CHECK && w_win)
          r_winner <= (r_gnt == G_P2) ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller: scoreboard of expected display snapshots, one entry per output change.
module tb_score_controller;
  localparam int WIN = 11;

  logic       dyn_clk = 1'b0;
  logic       reset = 1'b0;
  logic       point_p1 = 1'b0, point_p2 = 1'b0, undo = 1'b0, new_game = 1'b0;
  logic [3:0] p1_units, p1_tens, p2_units, p2_tens;
  logic [1:0] winner;
  logic       busy;

  score_controller #(.WIN_SCORE(WIN)) dut (
    .dyn_clk(dyn_clk), .reset(reset), .point_p1(point_p1), .point_p2(point_p2),
    .undo(undo), .new_game(new_game), .p1_units(p1_units), .p1_tens(p1_tens),
    .p2_units(p2_units), .p2_tens(p2_tens), .winner(winner), .busy(busy)
  );

  always #5 dyn_clk = ~dyn_clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [17:0] exp_q[$];
  int          m1 = 0, m2 = 0, m_last = 1;
  logic [1:0]  mw = 2'b00;
  bit          m_vld = 1'b0;

  function automatic logic [7:0] bcd(input int s);
    return {4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [17:0] snap();
    return {p1_tens, p1_units, p2_tens, p2_units, winner};
  endfunction

  function automatic logic [17:0] model_snap();
    return {bcd(m1), bcd(m2), mw};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic a, input logic b, input logic u);
    point_p1 = a; point_p2 = b; undo = u;
    @(negedge dyn_clk);
    point_p1 = 1'b0; point_p2 = 1'b0; undo = 1'b0;
  endtask

  task automatic wait_change(input string tag);
    logic [17:0] prev;
    logic [17:0] e;
    prev = snap();
    for (int i = 0; i < 16; i++) begin
      @(negedge dyn_clk);
      if (snap() !== prev) break;
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : prev;
    check(tag, snap(), e);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (!busy) break;
      @(negedge dyn_clk);
    end
    check(tag, busy, 0);
  endtask

  task automatic award(input int p);
    bit won;
    won = 1'b0;
    if (p == 1) m1++; else m2++;
    m_last = p; m_vld = 1'b1;
    exp_q.push_back(model_snap());
    if ((p == 1 ? m1 : m2) == WIN) begin
      mw = (p == 1) ? 2'b01 : 2'b10;
      exp_q.push_back(model_snap());
      won = 1'b1;
    end
    pulse(p == 1, p == 2, 1'b0);
    wait_change("point");
    if (won) wait_change("win_flag");
    else wait_idle("point_idle");
  endtask

  task automatic do_undo(input string tag);
    if (m_vld) begin
      if (m_last == 1) m1 = (m1 > 0) ? m1 - 1 : 0;
      else             m2 = (m2 > 0) ? m2 - 1 : 0;
      m_vld = 1'b0;
      exp_q.push_back(model_snap());
      pulse(1'b0, 1'b0, 1'b1);
      wait_change(tag);
      wait_idle({tag, "_idle"});
    end else begin
      pulse(1'b0, 1'b0, 1'b1);
      expect_stable(tag, 8);
    end
  endtask

  task automatic expect_stable(input string tag, input int n);
    repeat (n) @(negedge dyn_clk);
    check(tag, snap(), model_snap());
  endtask

  task automatic do_new_game();
    new_game = 1'b1;
    @(negedge dyn_clk);
    new_game = 1'b0;
    m1 = 0; m2 = 0; mw = 2'b00; m_vld = 1'b0;
    check("newgame_digits", snap(), model_snap());
    check("newgame_busy", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge dyn_clk);
    check("reset_digits", snap(), 18'h0);
    check("reset_busy", busy, 0);
    reset = 1'b1;
    @(negedge dyn_clk);

    // Single pulse latency: pending E0, grant E1, digits E2, idle E3
    point_p1 = 1'b1;
    @(negedge dyn_clk);
    point_p1 = 1'b0;
    check("e0_busy", busy, 0);
    check("e0_units", p1_units, 0);
    @(negedge dyn_clk);
    check("e1_busy", busy, 1);
    check("e1_units", p1_units, 0);
    @(negedge dyn_clk);
    check("e2_busy", busy, 1);
    check("e2_units", p1_units, 1);
    @(negedge dyn_clk);
    check("e3_busy", busy, 0);
    check("e3_winner", winner, 0);
    do_new_game();

    // Held-high input counts once
    m1 = 1; m_last = 1; m_vld = 1'b1;
    exp_q.push_back(model_snap());
    point_p1 = 1'b1;
    wait_change("hold_first");
    repeat (17) @(negedge dyn_clk);
    point_p1 = 1'b0;
    expect_stable("hold_once", 5);
    do_new_game();

    // BCD carry and one-level undo
    for (int i = 0; i < 10; i++) award(2);
    check("carry_tens", p2_tens, 1);
    check("carry_units", p2_units, 0);
    do_undo("undo_borrow");
    check("undo_units", p2_units, 9);
    do_undo("undo_invalid");
    do_new_game();

    // Simultaneous edges served round-robin
    m1 = 1; exp_q.push_back(model_snap());
    m2 = 1; exp_q.push_back(model_snap());
    pulse(1'b1, 1'b1, 1'b0);
    wait_change("rr1_first");
    wait_change("rr1_second");
    wait_idle("rr1_idle");
    m2 = 2; exp_q.push_back(model_snap());
    m1 = 2; exp_q.push_back(model_snap());
    pulse(1'b1, 1'b1, 1'b0);
    wait_change("rr2_first");
    wait_change("rr2_second");
    wait_idle("rr2_idle");
    do_new_game();

    // Win reached by the first of two simultaneous grants; the second is dropped
    for (int i = 0; i < WIN - 1; i++) award(1);
    m1 = WIN; exp_q.push_back(model_snap());
    mw = 2'b01; exp_q.push_back(model_snap());
    pulse(1'b1, 1'b1, 1'b0);
    wait_change("win_digits");
    wait_change("win_flag");
    check("won_busy", busy, 1);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    expect_stable("won_hold", 8);
    check("won_busy_hold", busy, 1);
    do_new_game();

    // Async reset mid-UPDATE with a request pending
    award(2);
    award(2);
    point_p1 = 1'b1;
    @(negedge dyn_clk);
    point_p1 = 1'b0;
    point_p2 = 1'b1;
    @(negedge dyn_clk);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_digits", snap(), 18'h0);
    check("rst_mid_busy", busy, 0);
    point_p2 = 1'b0;
    repeat (2) @(negedge dyn_clk);
    reset = 1'b1;
    m1 = 0; m2 = 0; mw = 2'b00; m_vld = 1'b0;
    expect_stable("no_stale", 10);
    check("no_stale_busy", busy, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/score_controller.md
Name: score_controller

Overview:
Two-player score sequencer for the pong scoreboard. It takes point and undo requests from the game logic. Requests can be level or multi-cycle. The block edge-detects and queues them, then arbitrates between the players so that one BCD update runs at a time. It maintains two 2-digit BCD scores, detects the winner and holds the game-over state until a new game starts. It feeds the digit display path directly.

Parameters:
WIN_SCORE, 11, points needed to win; legal range 1..99.

Ports:
dyn_clk     input   1  dynamic clock; all state changes on its rising edge
reset       input   1  asynchronous, active-low reset
point_p1    input   1  player 1 scored; rising edge = one request
point_p2    input   1  player 2 scored; rising edge = one request
undo        input   1  rising edge = remove the last awarded point
new_game    input   1  synchronous clear of scores and winner
p1_units    output  4  player 1 units digit, BCD
p1_tens     output  4  player 1 tens digit, BCD
p2_units    output  4  player 2 units digit, BCD
p2_tens     output  4  player 2 tens digit, BCD
winner      output  2  00 none, 01 player 1, 10 player 2
busy        output  1  high whenever the FSM is not in IDLE

Behaviour:
- reset low (async): all digits 0, winner 00, busy 0, FSM IDLE, pending flags 0, edge-detect history 0, undo history invalid, round-robin pointer favours player 1.
- Edge detect: the history register samples each request input every cycle. A request with current=1 and previous=0 sets its pending flag (pend_p1, pend_p2, pend_undo). A held-high input produces exactly one request.
- A pending flag set while the FSM is busy is kept and serviced later. A second edge on an input that is already pending is merged; it is not counted twice.
- FSM states: IDLE, UPDATE, CHECK, WON.
- IDLE, arbitration:
  - Point requests take priority over undo.
  - If both point flags are pending, grant the player not granted last; the round-robin pointer then toggles.
  - If only undo is pending and the undo history is valid, grant undo.
  - If only undo is pending and the history is invalid, clear pend_undo and take no action.
  - The granted pending flag clears. Next state is UPDATE.
- UPDATE, point grant:
  - Increment the player's BCD pair. units 9 -> 0 with tens+1; otherwise units+1.
  - Saturate at 99 (unreachable while WIN_SCORE<=99).
  - Record the player as last scorer and mark the undo history valid.
  - Next state is CHECK.
- UPDATE, undo grant:
  - Decrement the last scorer's pair. units 0 -> 9 with tens-1. A score of 00 stays 00.
  - Mark the undo history invalid (one level deep).
  - Next state is IDLE.
- CHECK: if the updated player's score (tens*10+units) equals WIN_SCORE, set winner and go to WON; otherwise go to IDLE.
- WON:
  - Scores and winner hold. point/undo edges are discarded and pending flags are forced to 0.
  - busy stays 1. Only new_game leaves this state.
- new_game is sampled high in any state and takes priority over everything else. On that edge:
  - digits 0, winner 00, pending flags 0, undo history invalid, FSM IDLE.
  - The round-robin pointer is kept.
- Latency: request first sampled high at edge E0 -> pending at E0 -> granted at E1 -> digits updated at E2 -> winner/IDLE at E3. Back-to-back service takes 3 cycles per point and 2 cycles per undo.
- Simultaneous point_p1 and point_p2 edges: both are queued and both are served, in round-robin order. If the first one served wins the game, the second is discarded.
- Reset asserted mid-operation: immediate async clear to the reset values above, with no partial update retained.

Test Plan:
- Reset, then one pulse on point_p1 at E0 -> p1_units=1 at E2, busy high for E1..E2, winner=00, IDLE at E3.
- point_p1 held high for 20 cycles -> exactly one increment; p1 score=01.
- Ten p2 points -> p2_tens=1, p2_units=0 (BCD carry); then an undo -> p2 reads 09; a second undo -> no change (history invalid).
- point_p1 and point_p2 rise on the same edge, twice in a row -> first pair grants p1 then p2, second pair grants p2 then p1; both scores end at 02.
- WIN_SCORE=11, player 1 reaches 11 -> winner=01 at CHECK+1. Further point/undo edges leave scores at 11/x. new_game -> all digits 0, winner=00, busy=0.
- Assert reset low mid-UPDATE with pending flags set -> all outputs 0 immediately. After release, no stale request is serviced.
